calc_result_display: RTL and testbench
======================================

Name: calc_result_display

Overview:
Downstream display stage for the calculator's 4-bit divider. It captures quotient, remainder and error on a one-cycle load strobe and converts each value to two decimal digits. It drives a time-multiplexed 4-digit common-anode 7-segment display: quotient on the left two digits, remainder on the right two. The error flag replaces the result with "Err", and a clear input returns the display to dashes.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays selected before the scan advances; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
quotient  input  4  divider quotient, 0..15
remainder  input  4  divider remainder, 0..15
error  input  1  divider divide-by-zero flag
load  input  1  one-cycle strobe; capture quotient/remainder/error this edge
clear  input  1  one-cycle strobe; return to BLANK state
an  output  4  digit enables, active-low; an[3] = leftmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Reset (async, rst=1):
  - state=BLANK, q_reg=0, r_reg=0, refresh counter=0, digit index=0.
  - an=4'b1111, seg=7'b1111111, dp=1 immediately, held while rst=1.
- Display states:
  - BLANK: after reset or clear. All four digits show dash.
  - RESULT: load with error=0.
  - ERROR: load with error=1.
- Transitions, evaluated each rising edge:
  - clear=1 -> BLANK. Clear wins over a simultaneous load.
  - Else load=1 -> ERROR if error=1, otherwise RESULT.
  - On a RESULT load, q_reg and r_reg capture the inputs. On an ERROR load they are left unchanged.
  - Else the state holds. Input changes without load are ignored.
  - load is accepted in any state; a new load overwrites the displayed result.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On the cycle the counter equals REFRESH_DIV-1, it wraps to 0 and digit index advances 0->1->2->3->0.
  - With REFRESH_DIV=1 the index advances every cycle.
  - load and clear never reset the scan.
- Outputs:
  - an, seg and dp are registered, computed from the next-cycle digit index and state.
  - an = active-low one-hot of the index: 0->1110, 1->1101, 2->1011, 3->0111.
  - First active an appears on the first edge after rst deasserts, with an=1110.
  - A load or clear at edge N is visible on the selected digit from edge N+1.
- Digit content:
  - RESULT:
    - d3 = quotient tens (1 or blank), d2 = quotient units, d1 = remainder tens (1 or blank), d0 = remainder units.
    - dp=0 on d2 only, as the separator; dp=1 on all other digits.
    - Tens digit is blank when the value < 10.
  - ERROR: d3="E", d2="r", d1="r", d0=blank; dp=1.
  - BLANK: all digits dash; dp=1.
- Segment codes:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Symbols: dash=0111111, E=0000110, r=0101111, blank=1111111.
- Decimal conversion: value>=10 gives tens=1, units=value-10; otherwise tens=blank, units=value. Inputs are 4-bit, so no value exceeds 15.

Test Plan:
1. Reset, REFRESH_DIV=4: rst high -> an=1111, seg=1111111, dp=1. Release -> an steps 1110,1101,1011,0111 every 4 cycles, seg=0111111 on every digit.
2. load with q=13, r=2, error=0:
   - an=0111 -> seg=1111001
   - an=1011 -> seg=0110000, dp=0
   - an=1101 -> seg=1111111
   - an=1110 -> seg=0100100
3. load with error=1 (q=15, r=15) -> digits show 0000110, 0101111, 0101111, 1111111; dp=1 throughout. A later load with q=4, r=10, error=0 shows blank, 0011001, 1111001, 1000000.
4. load and clear asserted in the same cycle, from RESULT -> BLANK: dashes on all digits from the next edge.
5. quotient/remainder changed without load -> display unchanged for 20 cycles.
6. rst asserted asynchronously mid-scan (index=2) -> outputs go to 1111/1111111/1 before the next edge. After release the scan restarts at an=1110 and the state is BLANK.

Source files
------------

// File: rtl/calc_result_display_if.sv
// Bus between the divider side and the result display: captured operands,
// strobes, and the multiplexed 7-segment drive.
interface calc_result_display_if;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       error;
  logic       load;
  logic       clear;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output quotient, remainder, error, load, clear,
    input  an, seg, dp
  );

  modport slave (
    input  quotient, remainder, error, load, clear,
    output an, seg, dp
  );
endinterface

// File: rtl/calc_result_display.sv
// Result display for the 4-bit divider: latches quotient/remainder/error on
// load and scans them onto a 4-digit common-anode 7-segment display.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_BLANK  | after reset or clear, dashes on every digit
// ST_RESULT | quotient on d3:d2, remainder on d1:d0, dp on d2
// ST_ERROR  | "Err" on d3..d1, d0 blank
module calc_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst,
  calc_result_display_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  typedef enum logic [1:0] {ST_BLANK, ST_RESULT, ST_ERROR} state_t;

  state_t        state, state_nxt;
  logic [3:0]    q_reg, r_reg, q_nxt, r_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [3:0]    q_units, r_units;
  logic [6:0]    q_tens_seg, r_tens_seg;

  // Units digit 0..9 to active-low segments.
  function automatic logic [6:0] digit_seg(input logic [3:0] v);
    case (v)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  // Next state, next scan position, and the segment pattern for the digit
  // that will be selected after this edge (outputs are registered from it).
  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    r_nxt     = r_reg;
    if (bus.clear) begin
      state_nxt = ST_BLANK;
    end else if (bus.load) begin
      if (bus.error) begin
        state_nxt = ST_ERROR;
      end else begin
        state_nxt = ST_RESULT;
        q_nxt     = bus.quotient;
        r_nxt     = bus.remainder;
      end
    end

    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end else begin
      cnt_nxt = cnt + 1'b1;
      idx_nxt = idx;
    end

    // Values are at most 15, so tens is either blank or a single '1'.
    q_units    = (q_nxt >= 4'd10) ? q_nxt - 4'd10 : q_nxt;
    r_units    = (r_nxt >= 4'd10) ? r_nxt - 4'd10 : r_nxt;
    q_tens_seg = (q_nxt >= 4'd10) ? SEG_ONE : SEG_BLANK;
    r_tens_seg = (r_nxt >= 4'd10) ? SEG_ONE : SEG_BLANK;

    an_nxt  = ~(4'b0001 << idx_nxt);
    seg_nxt = SEG_DASH;
    dp_nxt  = 1'b1;
    case (state_nxt)
      ST_RESULT: begin
        case (idx_nxt)
          2'd3:    seg_nxt = q_tens_seg;
          2'd2: begin
            seg_nxt = digit_seg(q_units);
            dp_nxt  = 1'b0;
          end
          2'd1:    seg_nxt = r_tens_seg;
          default: seg_nxt = digit_seg(r_units);
        endcase
      end
      ST_ERROR: begin
        case (idx_nxt)
          2'd3:       seg_nxt = SEG_E;
          2'd2, 2'd1: seg_nxt = SEG_R;
          default:    seg_nxt = SEG_BLANK;
        endcase
      end
      default: seg_nxt = SEG_DASH;
    endcase
  end

  // State, captured operands, scan position and registered display drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_BLANK;
      q_reg   <= '0;
      r_reg   <= '0;
      cnt     <= '0;
      idx     <= '0;
      bus.an  <= 4'b1111;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      state   <= state_nxt;
      q_reg   <= q_nxt;
      r_reg   <= r_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      bus.an  <= an_nxt;
      bus.seg <= seg_nxt;
      bus.dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: table of loads with expected digit patterns,
// hand-written corner sequences, then random traffic against a cycle model.
module tb_calc_result_display;

  localparam int D = 4;

  logic clk;
  logic rst;
  calc_result_display_if bus();

  calc_result_display #(.REFRESH_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: display mode (0 blank, 1 result, 2 error), stored
  // values, and edges since reset release (scan position follows from it).
  int m_state = 0;
  int m_q = 0;
  int m_r = 0;
  int m_k = 0;

  typedef struct packed {
    logic [3:0]  q;
    logic [3:0]  r;
    logic        err;
    logic [27:0] segs;  // {d3,d2,d1,d0}
    logic [3:0]  dps;   // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs [5];

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int cur_idx();
    return (m_k / D) % 4;
  endfunction

  // Expected {seg, dp} for the digit the model says is selected.
  function automatic logic [7:0] exp_out(input int d);
    logic [6:0] s;
    logic       p;
    s = 7'b0111111;
    p = 1'b1;
    if (m_state == 2) begin
      if (d == 3) s = 7'b0000110;
      else if (d == 0) s = 7'b1111111;
      else s = 7'b0101111;
    end else if (m_state == 1) begin
      if (d == 3) s = (m_q >= 10) ? seg_of(m_q / 10) : 7'b1111111;
      else if (d == 2) begin s = seg_of(m_q % 10); p = 1'b0; end
      else if (d == 1) s = (m_r >= 10) ? seg_of(m_r / 10) : 7'b1111111;
      else s = seg_of(m_r % 10);
    end
    return {s, p};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got an/seg/dp=%b_%b_%b expected %b_%b_%b", name,
                  act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
  endtask

  task automatic check_model(input string name);
    logic [3:0] a;
    a = 4'b1111 ^ 4'(1 << cur_idx());
    check(name, {bus.an, bus.seg, bus.dp}, {a, exp_out(cur_idx())});
  endtask

  task automatic check_reset(input string name);
    check(name, {bus.an, bus.seg, bus.dp}, 12'b1111_1111111_1);
  endtask

  // One clock: the model consumes the pre-edge inputs, then the DUT is
  // sampled 1ns after the edge and the strobes are dropped.
  task automatic tick(input string name);
    if (bus.clear) m_state = 0;
    else if (bus.load) begin
      if (bus.error) m_state = 2;
      else begin
        m_state = 1;
        m_q = int'(bus.quotient);
        m_r = int'(bus.remainder);
      end
    end
    m_k++;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    check_model(name);
  endtask

  task automatic model_reset();
    m_state = 0; m_q = 0; m_r = 0; m_k = 0;
  endtask

  initial begin
    vecs[0] = '{q: 4'd13, r: 4'd2,  err: 1'b0,
                segs: {7'b1111001, 7'b0110000, 7'b1111111, 7'b0100100}, dps: 4'b1011};
    vecs[1] = '{q: 4'd15, r: 4'd15, err: 1'b1,
                segs: {7'b0000110, 7'b0101111, 7'b0101111, 7'b1111111}, dps: 4'b1111};
    vecs[2] = '{q: 4'd4,  r: 4'd10, err: 1'b0,
                segs: {7'b1111111, 7'b0011001, 7'b1111001, 7'b1000000}, dps: 4'b1011};
    vecs[3] = '{q: 4'd0,  r: 4'd9,  err: 1'b0,
                segs: {7'b1111111, 7'b1000000, 7'b1111111, 7'b0010000}, dps: 4'b1011};
    vecs[4] = '{q: 4'd10, r: 4'd15, err: 1'b0,
                segs: {7'b1111001, 7'b1000000, 7'b1111001, 7'b0010010}, dps: 4'b1011};

    rst = 1'b1;
    bus.quotient = 4'd0; bus.remainder = 4'd0;
    bus.error = 1'b0; bus.load = 1'b0; bus.clear = 1'b0;

    // Reset held: blank outputs across several edges.
    repeat (3) @(posedge clk);
    #1 check_reset("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Scan from release: dashes, an stepping through all four digits.
    for (int i = 0; i < 5 * D; i++) tick("scan_blank");

    // Table of loads, each observed across a full scan.
    for (int v = 0; v < 5; v++) begin
      bus.quotient  = vecs[v].q;
      bus.remainder = vecs[v].r;
      bus.error     = vecs[v].err;
      bus.load      = 1'b1;
      for (int c = 0; c < 4 * D; c++) begin
        int d;
        tick("vec_model");
        d = cur_idx();
        check($sformatf("vec%0d_digit%0d", v, d), {bus.an, bus.seg, bus.dp},
              {4'b1111 ^ 4'(1 << d), vecs[v].segs[d*7 +: 7], vecs[v].dps[d]});
      end
    end

    // Clear wins over a simultaneous load.
    bus.quotient = 4'd7; bus.remainder = 4'd3; bus.error = 1'b0; bus.load = 1'b1;
    tick("load_before_clear");
    bus.quotient = 4'd12; bus.load = 1'b1; bus.clear = 1'b1;
    for (int c = 0; c < 4 * D; c++) begin
      tick("clear_vs_load");
      check("clear_dash", {5'b0, bus.seg}, {5'b0, 7'b0111111});
    end

    // Inputs move without load: display unchanged.
    bus.quotient = 4'd5; bus.remainder = 4'd6; bus.load = 1'b1;
    tick("load_5_6");
    for (int c = 0; c < 20; c++) begin
      bus.quotient  = 4'($urandom_range(0, 15));
      bus.remainder = 4'($urandom_range(0, 15));
      bus.error     = 1'($urandom_range(0, 1));
      tick("no_load_hold");
    end

    // Asynchronous reset mid-scan at digit index 2.
    for (int c = 0; c < 8 * D; c++) begin
      if (cur_idx() == 2 && (m_k % D) == 1) break;
      tick("to_idx2");
    end
    #2 rst = 1'b1;
    #1 check_reset("async_reset_mid");
    model_reset();
    @(negedge clk);
    #1 check_reset("async_reset_held");
    @(negedge clk);
    rst = 1'b0;
    tick("restart_after_reset");
    check("restart_an", {bus.an, 8'b0}, {4'b1110, 8'b0});
    for (int i = 0; i < D; i++) tick("blank_after_reset");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.quotient  = 4'($urandom_range(0, 15));
      bus.remainder = 4'($urandom_range(0, 15));
      bus.error     = ($urandom_range(0, 3) == 0);
      bus.load      = ($urandom_range(0, 3) == 0);
      bus.clear     = ($urandom_range(0, 15) == 0);
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
